// File: rtl/classificador_notas_seq_if.sv
// classificador_notas_seq_if: switch-side strobes in, display/status outputs back from the grade buffer
interface classificador_notas_seq_if #(
  parameter int NOTA_BITS = 4,
  parameter int DEPTH     = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [NOTA_BITS-1:0] nota;
  logic                 wr;
  logic                 clr;
  logic                 modo;
  logic [7:0]           seg;
  logic [CW-1:0]        count;
  logic [IW-1:0]        idx;
  logic                 full;
  logic                 err;
  logic [CW-1:0]        count_a;
  logic [CW-1:0]        count_f;
  logic [CW-1:0]        count_p;
  modport master (
    output nota, wr, clr, modo,
    input  seg, count, idx, full, err, count_a, count_f, count_p
  );
  modport slave (
    input  nota, wr, clr, modo,
    output seg, count, idx, full, err, count_a, count_f, count_p
  );
endinterface

// File: rtl/classificador_notas_seq.sv
// classificador_notas_seq: buffers strobed grades and rotates them on a 7-seg display; CLASSIF_STATS_EN adds per-class counters
module classificador_notas_seq #(
  parameter int NOTA_BITS = 4,
  parameter int MAX_NOTA  = 9,
  parameter int LIM_A     = 7,
  parameter int LIM_F     = 4,
  parameter int DEPTH     = 8,
  parameter int DWELL     = 4
) (
  input logic                      clk_2,
  input logic                      reset,
  classificador_notas_seq_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int DW = $clog2(DWELL + 1);
  typedef enum logic {VAZIO, EXIBE} estado_t;
  estado_t              state, state_n;
  logic                 wr_q;
  logic [CW-1:0]        count;
  logic [IW-1:0]        idx, idx_n;
  logic [DW-1:0]        dwell, dwell_n;
  logic [NOTA_BITS-1:0] buffer [DEPTH];
  logic [NOTA_BITS-1:0] atual;
  logic [6:0]           padrao;
  logic [7:0]           seg;
  logic                 ev, valido, full, aceita, rejeita, fim, ultimo, err;

  function automatic logic [6:0] digito(input logic [NOTA_BITS-1:0] v);
    case (int'(v))
      0:       digito = 7'h3F;
      1:       digito = 7'h06;
      2:       digito = 7'h5B;
      3:       digito = 7'h4F;
      4:       digito = 7'h66;
      5:       digito = 7'h6D;
      6:       digito = 7'h7D;
      7:       digito = 7'h07;
      8:       digito = 7'h7F;
      9:       digito = 7'h6F;
      default: digito = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] letra(input logic [NOTA_BITS-1:0] v);
    letra = v >= NOTA_BITS'(LIM_A) ? 7'h77 : v >= NOTA_BITS'(LIM_F) ? 7'h71 : 7'h73;
  endfunction

  assign ev      = bus.wr & ~wr_q;
  assign valido  = bus.nota <= NOTA_BITS'(MAX_NOTA);
  assign full    = count == CW'(DEPTH);
  assign aceita  = ev & ~bus.clr & valido & ~full;
  assign rejeita = ev & ~bus.clr & ~(valido & ~full);
  assign fim     = dwell == DW'(DWELL - 1);
  assign ultimo  = CW'(idx) + 1'b1 >= count;
  assign atual   = buffer[idx];
  assign padrao  = bus.modo ? letra(atual) : digito(atual);

  // wr_q follows wr even during reset, so a wr held through reset is not seen as a new edge
  always_ff @(posedge clk_2)
    wr_q <= bus.wr;

  // stored-entry count and one-cycle reject pulse; clr suppresses both store and reject
  always_ff @(posedge clk_2) begin
    count <= (reset || bus.clr) ? '0 : aceita ? count + 1'b1 : count;
    err   <= reset ? 1'b0 : rejeita;
  end

  // grade storage; contents are not cleared, count alone defines the valid entries
  always_ff @(posedge clk_2)
    if (aceita) buffer[count[IW-1:0]] <= bus.nota;

  // display FSM state register with rotation position and dwell timer
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state <= VAZIO;
      idx   <= '0;
      dwell <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      dwell <= dwell_n;
    end
  end

  // rotation: dwell runs 0..DWELL-1, then idx advances and wraps against the live count
  always_comb begin
    state_n = bus.clr ? VAZIO : (state == VAZIO && aceita) ? EXIBE : state;
    dwell_n = (bus.clr || state == VAZIO || fim) ? '0 : dwell + 1'b1;
    idx_n   = (bus.clr || state == VAZIO) ? '0 : !fim ? idx : ultimo ? '0 : idx + 1'b1;
  end

  // registered display: dash while empty, otherwise the current entry with dp on entry 0
  always_ff @(posedge clk_2)
    seg <= reset ? 8'h40 : (state == EXIBE) ? {idx == '0, padrao} : 8'h40;

  assign bus.seg   = seg;
  assign bus.count = count;
  assign bus.idx   = idx;
  assign bus.full  = full;
  assign bus.err   = err;

`ifdef CLASSIF_STATS_EN
  logic [CW-1:0] cnt_a, cnt_f, cnt_p;
  // per-class totals of accepted grades, cleared together with the buffer
  always_ff @(posedge clk_2) begin
    if (reset || bus.clr) begin
      cnt_a <= '0;
      cnt_f <= '0;
      cnt_p <= '0;
    end else if (aceita) begin
      cnt_a <= cnt_a + CW'(bus.nota >= NOTA_BITS'(LIM_A));
      cnt_f <= cnt_f + CW'(bus.nota >= NOTA_BITS'(LIM_F) && bus.nota < NOTA_BITS'(LIM_A));
      cnt_p <= cnt_p + CW'(bus.nota < NOTA_BITS'(LIM_F));
    end
  end
  assign bus.count_a = cnt_a;
  assign bus.count_f = cnt_f;
  assign bus.count_p = cnt_p;
`else
  assign bus.count_a = '0;
  assign bus.count_f = '0;
  assign bus.count_p = '0;
`endif
endmodule

// File: tb/tb_classificador_notas_seq.sv
// tb_classificador_notas_seq: directed scenarios plus random traffic against a list-based reference model
module tb_classificador_notas_seq;
  localparam int DWELL = 4;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   modo = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  always #5 clk = ~clk;

  classificador_notas_seq_if #(.NOTA_BITS(4), .DEPTH(DEPTH)) bus ();
  classificador_notas_seq #(
    .NOTA_BITS(4), .MAX_NOTA(9), .LIM_A(7), .LIM_F(4), .DEPTH(DEPTH), .DWELL(DWELL)
  ) dut (
    .clk_2(clk),
    .reset(reset),
    .bus  (bus)
  );

  int         q[$];
  int         m_pos, m_age, m_na, m_nf, m_np;
  bit         m_on, m_wrq, m_err;
  logic [7:0] m_seg;
  int         digs[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input int n, input bit m, input bit dp);
    int p;
    p = m ? (n >= 7 ? 'h77 : n >= 4 ? 'h71 : 'h73) : digs[n];
    return {dp, p[6:0]};
  endfunction

  task automatic model_reset(input bit w);
    q.delete();
    m_on = 0; m_pos = 0; m_age = 0; m_err = 0; m_seg = 8'h40; m_wrq = w;
    m_na = 0; m_nf = 0; m_np = 0;
  endtask

  task automatic model_edge(input bit w, input bit c, input int n, input bit m);
    bit ev;
    ev = w && !m_wrq;
    m_seg = m_on ? enc(q[m_pos], m, m_pos == 0) : 8'h40;
    m_wrq = w;
    m_err = 0;
    if (c) begin
      q.delete();
      m_on = 0; m_pos = 0; m_age = 0; m_na = 0; m_nf = 0; m_np = 0;
    end else begin
      if (m_on) begin
        m_age++;
        if (m_age == DWELL) begin
          m_age = 0;
          m_pos = (m_pos + 1 >= q.size()) ? 0 : m_pos + 1;
        end
      end
      if (ev) begin
        if (n > 9 || q.size() == DEPTH) m_err = 1;
        else begin
          q.push_back(n);
          if (n >= 7) m_na++; else if (n >= 4) m_nf++; else m_np++;
          if (!m_on) begin m_on = 1; m_pos = 0; m_age = 0; end
        end
      end
    end
  endtask

  task automatic step(input bit w, input bit c, input int n);
    bus.wr = w; bus.clr = c; bus.nota = 4'(n); bus.modo = modo;
    @(posedge clk);
    if (reset) model_reset(w); else model_edge(w, c, n, modo);
    #1;
    chk("seg", bus.seg, m_seg);
    chk("count", bus.count, q.size());
    chk("idx", bus.idx, m_pos);
    chk("full", bus.full, q.size() == DEPTH);
    chk("err", bus.err, m_err);
`ifdef CLASSIF_STATS_EN
    chk("count_a", bus.count_a, m_na);
    chk("count_f", bus.count_f, m_nf);
    chk("count_p", bus.count_p, m_np);
`else
    chk("count_a", bus.count_a, 0);
    chk("count_f", bus.count_f, 0);
    chk("count_p", bus.count_p, 0);
`endif
  endtask

  task automatic store(input int n);
    step(1, 0, n);
    step(0, 0, n);
  endtask

  initial begin
    bus.wr = 0; bus.clr = 0; bus.nota = '0; bus.modo = 0;
    reset = 1;
    repeat (3) step(1, 0, 0);
    reset = 0;
    repeat (3) step(1, 0, 0);
    chk("held_wr_no_store", bus.count, 0);
    repeat (10) step(0, 0, 0);
    chk("idle_seg", bus.seg, 8'h40);
    store(9); store(5); store(2);
    repeat (30) step(0, 0, 0);
    modo = 1;
    repeat (30) step(0, 0, 0);
    modo = 0;
`ifdef CLASSIF_STATS_EN
    chk("stats_a", bus.count_a, 1);
    chk("stats_f", bus.count_f, 1);
    chk("stats_p", bus.count_p, 1);
`endif
    step(0, 1, 0);
    for (int i = 0; i < DEPTH; i++) store((i * 3 + 1) % 10);
    step(1, 0, 3);
    chk("ninth_err", bus.err, 1);
    step(0, 0, 3);
    chk("err_one_cycle", bus.err, 0);
    chk("full_const", bus.full, 1);
    chk("count_full", bus.count, DEPTH);
    repeat (40) step(0, 0, 0);
    step(0, 1, 0);
    step(1, 0, 12);
    chk("bad_grade_err", bus.err, 1);
    step(0, 0, 12);
    chk("bad_grade_count", bus.count, 0);
    repeat (20) step(1, 0, 6);
    step(0, 0, 6);
    chk("held_one_store", bus.count, 1);
    step(0, 0, 0);
    step(1, 1, 3);
    step(0, 0, 3);
    step(0, 0, 3);
    chk("clr_wins_seg", bus.seg, 8'h40);
    chk("clr_wins_count", bus.count, 0);
    for (int i = 0; i < 5; i++) store(i + 4);
    repeat (7) step(0, 0, 0);
    reset = 1;
    step(1, 1, 2);
    reset = 0;
    chk("rst_seg", bus.seg, 8'h40);
    chk("rst_count", bus.count, 0);
    step(0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      bit w, c;
      int n;
      w = $urandom_range(0, 2) == 0;
      c = $urandom_range(0, 59) == 0;
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      if ($urandom_range(0, 40) == 0) modo = ~modo;
      reset = $urandom_range(0, 299) == 0;
      step(w, c, n);
    end
    reset = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
